// File: rtl/regfile_sequencer.sv
// regfile_sequencer: fetches one micro-instruction, reads two registers, runs the ALU, writes back.
// Define REGSEQ_FLAGS_EN to add the registered carry/borrow (C) and overflow (V) outputs.
module regfile_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int READ_WAIT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              INST_VALID,
  output logic              INST_READY,
  input  logic [15:0]       INST,
  output logic [ADDR_W-1:0] AA,
  output logic [ADDR_W-1:0] BA,
  output logic [ADDR_W-1:0] DA,
  output logic [DATA_W-1:0] DD,
  output logic              RW,
  input  logic [DATA_W-1:0] AD,
  input  logic [DATA_W-1:0] BD,
  output logic [DATA_W-1:0] RESULT,
  output logic              Z,
  output logic              DONE
`ifdef REGSEQ_FLAGS_EN
  ,
  output logic              C,
  output logic              V
`endif
);

  // state | meaning
  // IDLE  | ready for an instruction, address/data outputs hold last values
  // READ  | AA/BA driven from the latched instruction, waiting READ_WAIT cycles
  // EXEC  | AD/BD valid, RESULT/Z (and flags) registered on the edge leaving
  // WRITE | single-cycle DONE, RW strobe unless the op is a NOP
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;
  localparam logic [1:0] WAIT_LOAD = 2'(READ_WAIT - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       inst_q, inst_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        op;

  assign op = inst_q[15:12];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    ready_d = ready_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (INST_VALID && ready_q) begin
          inst_d  = INST;
          cnt_d   = WAIT_LOAD;
          state_d = S_READ;
          ready_d = 1'b0;
        end
      end
      S_READ: begin
        if (cnt_q == 2'd0) state_d = S_EXEC;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_EXEC: state_d = S_WRITE;
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:    alu_res = AD;
      4'd1:    alu_res = AD + BD;
      4'd2:    alu_res = AD - BD;
      4'd3:    alu_res = AD & BD;
      4'd4:    alu_res = AD | BD;
      4'd5:    alu_res = AD ^ BD;
      4'd6:    alu_res = ~AD;
      4'd7:    alu_res = {AD[DATA_W-2:0], 1'b0};
      4'd8:    alu_res = {1'b0, AD[DATA_W-1:1]};
      4'd9:    alu_res = {{(DATA_W-6){1'b0}}, inst_q[5:0]};
      default: alu_res = '0;
    endcase
    result_d = (state_q == S_EXEC) ? alu_res : result_q;
    z_d      = (state_q == S_EXEC) ? (alu_res == '0) : z_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      inst_q   <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inst_q   <= inst_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      z_q      <= z_d;
    end
  end

`ifdef REGSEQ_FLAGS_EN
  logic c_q, c_d, v_q, v_d;
  logic alu_c, alu_v;

  // Carry and overflow are recovered from operand and result MSBs, avoiding a wider adder.
  always_comb begin
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      4'd1: begin
        alu_c = (AD[DATA_W-1] & BD[DATA_W-1]) |
                ((AD[DATA_W-1] | BD[DATA_W-1]) & ~alu_res[DATA_W-1]);
        alu_v = (AD[DATA_W-1] == BD[DATA_W-1]) && (alu_res[DATA_W-1] != AD[DATA_W-1]);
      end
      4'd2: begin
        alu_c = (AD < BD);
        alu_v = (AD[DATA_W-1] != BD[DATA_W-1]) && (alu_res[DATA_W-1] != AD[DATA_W-1]);
      end
      4'd7:    alu_c = AD[DATA_W-1];
      4'd8:    alu_c = AD[0];
      default: ;
    endcase
    c_d = (state_q == S_EXEC) ? alu_c : c_q;
    v_d = (state_q == S_EXEC) ? alu_v : v_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign C = c_q;
  assign V = v_q;
`endif

  // RW/DONE decode straight from the state flop so an async reset kills them at once.
  assign INST_READY = ready_q;
  assign AA         = ADDR_W'(inst_q[8:6]);
  assign BA         = ADDR_W'(inst_q[5:3]);
  assign DA         = ADDR_W'(inst_q[11:9]);
  assign DD         = result_q;
  assign RESULT     = result_q;
  assign Z          = z_q;
  assign DONE       = (state_q == S_WRITE);
  assign RW         = (state_q == S_WRITE) && (op <= 4'd9);

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed and randomized checks of regfile_sequencer against
// a behavioural register-file/ALU model; C/V checks compiled in with REGSEQ_FLAGS_EN.
`timescale 1ns/1ps
module tb_regfile_sequencer;
  localparam int READ_WAIT = 1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        INST_VALID = 1'b0;
  logic        INST_READY;
  logic [15:0] INST = '0;
  logic [2:0]  AA, BA, DA;
  logic [15:0] DD, AD, BD, RESULT;
  logic        RW, Z, DONE;
`ifdef REGSEQ_FLAGS_EN
  logic        C, V;
`endif

  logic [15:0] rf [8];
  logic [15:0] exp_rf [8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  int          wr_cnt = 0;
  int          cyc = 0;
  int          hs_cyc [$];
  int          n_checks = 0;
  int          n_fail = 0;

  regfile_sequencer #(.DATA_W(16), .ADDR_W(3), .READ_WAIT(READ_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .INST_VALID(INST_VALID), .INST_READY(INST_READY),
    .INST(INST), .AA(AA), .BA(BA), .DA(DA), .DD(DD), .RW(RW), .AD(AD), .BD(BD),
    .RESULT(RESULT), .Z(Z), .DONE(DONE)
`ifdef REGSEQ_FLAGS_EN
    , .C(C), .V(V)
`endif
  );

  always #5 CLK = ~CLK;

  assign AD = rf[AA];
  assign BD = rf[BA];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (INST_VALID && INST_READY) hs_cyc.push_back(cyc);
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (RW) begin
      rf[DA] <= DD;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic logic [15:0] ref_result(input logic [15:0] inst, input logic [15:0] a, input logic [15:0] b);
    case (inst[15:12])
      4'd0:    return a;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return ~a;
      4'd7:    return a << 1;
      4'd8:    return a >> 1;
      4'd9:    return {10'b0, inst[5:0]};
      default: return 16'h0000;
    endcase
  endfunction

`ifdef REGSEQ_FLAGS_EN
  function automatic logic [1:0] ref_cv(input logic [15:0] inst, input logic [15:0] a, input logic [15:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'(signed'(a));
    int sb = int'(signed'(b));
    case (inst[15:12])
      4'd1:    return {(ua + ub) > 65535, (sa + sb > 32767) || (sa + sb < -32768)};
      4'd2:    return {ua < ub, (sa - sb > 32767) || (sa - sb < -32768)};
      4'd7:    return {a[15], 1'b0};
      4'd8:    return {a[0], 1'b0};
      default: return 2'b00;
    endcase
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rf_match();
    for (int i = 0; i < 8; i++)
      if (rf[i] !== exp_rf[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic preload(input logic [2:0] addr, input logic [15:0] data);
    pre_en = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge CLK);
    pre_en = 1'b0;
    exp_rf[addr] = data;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (INST_READY !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("ready_wait", INST_READY, 1);
  endtask

  // Issues one instruction at a negedge and checks every cycle until it is back in IDLE.
  task automatic run_inst(input logic [15:0] inst);
    logic [2:0]  da = inst[11:9];
    logic [2:0]  aa = inst[8:6];
    logic [2:0]  ba = inst[5:3];
    logic [15:0] a, b, res;
    logic        wr;
    wait_ready();
    a   = exp_rf[aa];
    b   = exp_rf[ba];
    res = ref_result(inst, a, b);
    wr  = (inst[15:12] <= 4'd9);
    INST_VALID = 1'b1;
    INST = inst;
    @(negedge CLK);
    INST_VALID = 1'b0;
    INST = 16'($urandom);
    for (int j = 0; j < READ_WAIT + 1; j++) begin
      chk("read_aa", AA, aa);
      chk("read_ba", BA, ba);
      chk("read_rw", RW, 0);
      chk("read_done", DONE, 0);
      chk("read_ready", INST_READY, 0);
      @(negedge CLK);
    end
    chk("write_rw", RW, wr);
    chk("write_done", DONE, 1);
    chk("write_da", DA, da);
    chk("write_dd", DD, res);
    chk("write_result", RESULT, res);
    chk("write_z", Z, res == 16'h0000);
    chk("write_ready", INST_READY, 0);
`ifdef REGSEQ_FLAGS_EN
    chk("write_c", C, ref_cv(inst, a, b) >> 1);
    chk("write_v", V, ref_cv(inst, a, b) & 2'b01);
`endif
    @(negedge CLK);
    if (wr) exp_rf[da] = res;
    chk("idle_rw", RW, 0);
    chk("idle_done", DONE, 0);
    chk("idle_ready", INST_READY, 1);
    chk("idle_dd_hold", DD, res);
    chk("rf_contents", rf_match(), 1);
  endtask

  initial begin
    logic [15:0] x1, x2;
    int hs0, w0;
    RESET = 1'b1;
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    chk("rst_ready", INST_READY, 0);
    chk("rst_rw", RW, 0);
    chk("rst_done", DONE, 0);
    chk("rst_aa", AA, 0);
    chk("rst_da", DA, 0);
    chk("rst_dd", DD, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_z", Z, 0);
    RESET = 1'b0;
    #1;
    chk("ready_before_edge", INST_READY, 0);
    @(negedge CLK);
    chk("ready_after_edge", INST_READY, 1);

    run_inst(16'h9A15);
    preload(3'd1, 16'h7FFF);
    preload(3'd2, 16'h0001);
    run_inst(16'h1650);
    preload(3'd4, 16'h1234);
    run_inst(16'h2120);
    run_inst(16'hF000);
    preload(3'd5, 16'h0003);
    run_inst({4'd1, 3'd5, 3'd5, 3'd5, 3'd0});

    // Back-to-back: second instruction depends on the first one's destination.
    x1 = {4'd1, 3'd6, 3'd1, 3'd2, 3'd0};
    x2 = {4'd5, 3'd7, 3'd6, 3'd1, 3'd0};
    wait_ready();
    hs0 = hs_cyc.size();
    INST_VALID = 1'b1;
    INST = x1;
    @(negedge CLK);
    INST = x2;
    for (int j = 0; j < READ_WAIT + 2; j++) begin
      chk("b2b_ready_low", INST_READY, 0);
      @(negedge CLK);
    end
    chk("b2b_ready_high", INST_READY, 1);
    @(negedge CLK);
    INST_VALID = 1'b0;
    w0 = 0;
    while (DONE !== 1'b1 && w0 < 20) begin
      @(negedge CLK);
      w0++;
    end
    chk("b2b_done", DONE, 1);
    @(negedge CLK);
    exp_rf[6] = ref_result(x1, exp_rf[1], exp_rf[2]);
    exp_rf[7] = ref_result(x2, exp_rf[6], exp_rf[1]);
    chk("b2b_hs_count", hs_cyc.size() - hs0, 2);
    if (hs_cyc.size() >= hs0 + 2)
      chk("b2b_spacing", hs_cyc[hs0+1] - hs_cyc[hs0], 3 + READ_WAIT);
    chk("b2b_rf", rf_match(), 1);

    // Reset during the WRITE cycle of an ADD must suppress the write.
    preload(3'd3, 16'h0000);
    wait_ready();
    w0 = wr_cnt;
    INST_VALID = 1'b1;
    INST = 16'h1650;
    @(negedge CLK);
    INST_VALID = 1'b0;
    repeat (READ_WAIT + 1) @(negedge CLK);
    chk("abort_in_write", RW, 1);
    #2 RESET = 1'b1;
    #1;
    chk("abort_rw_async", RW, 0);
    chk("abort_done_async", DONE, 0);
    chk("abort_ready", INST_READY, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("abort_ready_pre_edge", INST_READY, 0);
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_rf", rf_match(), 1);
    @(negedge CLK);
    chk("abort_ready_post_edge", INST_READY, 1);
    chk("abort_result_cleared", RESULT, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) preload(3'($urandom_range(0, 7)), 16'($urandom));
      run_inst(16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

endmodule
